soc_system_version_word_gen: RTL and testbench
==============================================

Name: soc_system_version_word_gen

Overview:
- Upstream feeder for the 32-bit read-only version/status PIO; drives that PIO's in_port.
- Presents one of several paged 32-bit words, selected by a page index that an HPS-written output PIO drives:
  - firmware version
  - build date
  - uptime seconds
  - trigger count
  - live status flags
- Registers the output and accepts a new page only after the index has been stable for 2 cycles, so the PIO never samples a torn multi-bit transition.

Parameters:
- FW_VERSION, 32'h0001_0000, constant returned on page 0 (major[31:16], minor[15:0]).
- BUILD_DATE, 32'h2021_0101, constant returned on page 1 (BCD YYYYMMDD).
- CLK_FREQ_HZ, 50000000, clk frequency; the uptime prescaler terminal count is CLK_FREQ_HZ-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- page_sel  in  3  requested page index from the HPS output PIO; asynchronous to software intent, changes on any clk.
- trig_in  in  1  DAQ trigger level; each rising edge counts one trigger.
- cnt_clear  in  1  synchronous clear of the trigger count and uptime.
- daq_busy  in  1  live busy flag.
- fifo_full  in  1  live event-FIFO full flag.
- status_word  out  32  registered word feeding PIO in_port.
- sec_tick  out  1  one-cycle pulse per elapsed second.

Behaviour:
- Reset (async assert, sync-to-clk deassert not required):
  - status_word=FW_VERSION, sec_tick=0.
  - Prescaler=0, uptime=0, trig_cnt=0.
  - trig_d=0, page_q=0, page_stable=0, stab_cnt=0.
- Page qualification:
  - page_sel is registered into page_d each cycle.
  - If page_d==previous page_d, stab_cnt increments, saturating at 2; otherwise stab_cnt=0.
  - When stab_cnt reaches 2, page_stable<=page_d.
  - Latency from a stable page_sel change to the status_word content change is 4 clk cycles. The bench measures exactly 4.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1 and wraps.
  - On wrap, sec_tick=1 for that cycle and uptime increments.
  - uptime is 32-bit and wraps 0xFFFFFFFF->0.
- Trigger counter:
  - trig_d<=trig_in; a rise is detected when trig_in & ~trig_d.
  - trig_cnt is 32-bit and saturates at 0xFFFFFFFF; it does not wrap.
- cnt_clear:
  - Highest priority over increments in the same cycle.
  - Clears prescaler, uptime and trig_cnt; sec_tick=0 in that cycle.
  - An edge coinciding with clear is lost. trig_d still updates.
- Output mux, registered every cycle from page_stable:
  - 0: FW_VERSION
  - 1: BUILD_DATE
  - 2: uptime
  - 3: trig_cnt
  - 4: {28'b0, trig_d, fifo_full, daq_busy, 1'b1}; bit0 is a constant alive marker.
  - 5..7: 32'hDEAD_BEEF.
  - Live counters update status_word on the cycle after their own increment.
- Reset mid-count: all state returns immediately to reset values and status_word returns to page 0. After release, page_sel must again be stable 2 cycles before any non-zero page takes effect.
- Page glitch: if page_sel toggles faster than the 2-cycle stability window, status_word retains the last qualified page indefinitely.
- No combinational path from any input to status_word or sec_tick.

Test Plan:
- Reset, then page_sel=0 held -> status_word=32'h0001_0000. Set page_sel=1 at cycle t -> status_word=32'h2021_0101 exactly at t+4, unchanged before.
- CLK_FREQ_HZ=10, page 2, run 35 cycles after reset -> sec_tick pulses at cycles 10,20,30 and status_word=3. Assert cnt_clear at cycle 34 -> status_word=0 two cycles later.
- page 3, 5 trig_in pulses (each 3 cycles high, 2 low) -> status_word=5. trig_in held high 20 cycles -> still counts 1 more (6). Edge coincident with cnt_clear -> count=0.
- Force trig_cnt to 0xFFFFFFFE (hierarchical deposit) and apply 3 rising edges -> status_word=0xFFFFFFFF, stays.
- Page 4 with daq_busy=1, fifo_full=0, trig_in=1 -> status_word=32'h0000_000B. Pages 5,6,7 -> 32'hDEAD_BEEF.
- Alternate page_sel between 2 and 3 every cycle for 50 cycles from qualified page 1 -> status_word stays 32'h2021_0101. Assert reset mid-run -> status_word=FW_VERSION in the same cycle, counters 0.

Source files
------------

// File: rtl/soc_system_version_word_gen.sv
// soc_system_version_word_gen
// Builds the 32-bit paged word that feeds the read-only version/status PIO.
// Software picks a page through page_sel. A page is only accepted after
// page_sel has held the same value for long enough, so the PIO never sees a
// word selected by a half-changed index. The word is always driven from a
// register, so no input reaches status_word or sec_tick combinationally.

module soc_system_version_word_gen #(
  parameter logic [31:0] FW_VERSION    = 32'h0001_0000,
  parameter logic [31:0] BUILD_DATE    = 32'h2021_0101,
  parameter int unsigned CLK_FREQ_HZ   = 50000000,
  // Trigger count value loaded at reset. Keep it at zero in normal use. A
  // nonzero value pre-loads the counter close to saturation. cnt_clear always
  // returns the count to zero.
  parameter logic [31:0] TRIG_CNT_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  page_sel,
  input  logic        trig_in,
  input  logic        cnt_clear,
  input  logic        daq_busy,
  input  logic        fifo_full,
  output logic [31:0] status_word,
  output logic        sec_tick
);

  // Page indices
  localparam logic [2:0] PAGE_FW     = 3'd0;
  localparam logic [2:0] PAGE_DATE   = 3'd1;
  localparam logic [2:0] PAGE_UPTIME = 3'd2;
  localparam logic [2:0] PAGE_TRIG   = 3'd3;
  localparam logic [2:0] PAGE_STATUS = 3'd4;

  localparam logic [31:0] UNUSED_PAGE_WORD = 32'hDEAD_BEEF;
  localparam logic [31:0] TRIG_CNT_MAX     = 32'hFFFF_FFFF;

  // The prescaler counts 0 .. CLK_FREQ_HZ-1.
  localparam int unsigned   PRESC_W  = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_FREQ_HZ - 1);

  // ---------------------------------------------------------------------------
  // Page qualification
  // ---------------------------------------------------------------------------
  // page_d is the registered copy of page_sel. The incoming page_sel is
  // compared against page_d, which holds the value from the previous cycle.
  // stab_cnt counts consecutive matching samples and saturates at 2.
  // page_stable loads page_d on the cycle stab_cnt reaches 2. The result is a
  // fixed latency: page_sel change -> page_d -> +1 -> page_stable ->
  // status_word, which is 4 clocks in total.
  logic [2:0] page_d;
  logic [2:0] page_stable;
  logic [1:0] stab_cnt;
  logic [1:0] stab_cnt_nxt;
  logic       page_same;
  logic       page_load;

  // Stability counter next state and the page-accept strobe.
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    stab_cnt_nxt = 2'd0;
    page_same    = (page_sel == page_d);
    if (page_same) begin
      stab_cnt_nxt = (stab_cnt == 2'd2) ? 2'd2 : stab_cnt + 2'd1;
    end
    page_load = (stab_cnt_nxt == 2'd2);
  end

  // Page sample, stability count and qualified page registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments, so every register
    // in the block samples the pre-edge values, whatever the statement order.
    if (reset) begin
      page_d      <= PAGE_FW;
      stab_cnt    <= 2'd0;
      page_stable <= PAGE_FW;
    end else begin
      page_d   <= page_sel;
      stab_cnt <= stab_cnt_nxt;
      if (page_load) begin
        page_stable <= page_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Uptime: prescaler plus a seconds counter
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc;
  logic [31:0]        uptime;
  logic               presc_wrap;

  assign presc_wrap = (presc == PRESC_TC);

  // Prescaler wrap produces one sec_tick and advances uptime. cnt_clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      uptime   <= 32'd0;
      sec_tick <= 1'b0;
    end else if (cnt_clear) begin
      presc    <= '0;
      uptime   <= 32'd0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= presc_wrap;
      if (presc_wrap) begin
        presc  <= '0;
        uptime <= uptime + 32'd1;   // wraps naturally at 2^32
      end else begin
        presc  <= presc + PRESC_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Trigger counter
  // ---------------------------------------------------------------------------
  logic        trig_d;
  logic [31:0] trig_cnt;
  logic        trig_rise;

  assign trig_rise = trig_in & ~trig_d;

  // Rising-edge counter that saturates. trig_d tracks trig_in every cycle,
  // even during a clear, so an edge that lands on a clear is not counted later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_d   <= 1'b0;
      trig_cnt <= TRIG_CNT_INIT;
    end else begin
      trig_d <= trig_in;
      if (cnt_clear) begin
        trig_cnt <= 32'd0;
      end else if (trig_rise && (trig_cnt != TRIG_CNT_MAX)) begin
        trig_cnt <= trig_cnt + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output word
  // ---------------------------------------------------------------------------
  logic [31:0] word_nxt;

  // Select the page contents from the qualified page index.
  always_comb begin
    word_nxt = UNUSED_PAGE_WORD;
    case (page_stable)
      PAGE_FW:     word_nxt = FW_VERSION;
      PAGE_DATE:   word_nxt = BUILD_DATE;
      PAGE_UPTIME: word_nxt = uptime;
      PAGE_TRIG:   word_nxt = trig_cnt;
      PAGE_STATUS: word_nxt = {28'd0, trig_d, fifo_full, daq_busy, 1'b1};
      default:     word_nxt = UNUSED_PAGE_WORD;
    endcase
  end

  // Register the selected word so the PIO always samples a settled value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_word <= FW_VERSION;
    end else begin
      status_word <= word_nxt;
    end
  end

endmodule

// File: tb/tb_soc_system_version_word_gen.sv
// Testbench for soc_system_version_word_gen.
// Directed steps run first, then a randomized phase that is compared each
// cycle against a behavioural model. The model describes the block in terms
// of cycles since the last clear and runs of identical page_sel samples.

module tb_soc_system_version_word_gen;

  localparam int unsigned CLK_HZ   = 10;
  localparam logic [31:0] FW       = 32'h0001_0000;
  localparam logic [31:0] BUILD    = 32'h2021_0101;
  localparam logic [31:0] BEEF     = 32'hDEAD_BEEF;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  page_sel;
  logic        trig_in;
  logic        cnt_clear;
  logic        daq_busy;
  logic        fifo_full;
  logic [31:0] status_word;
  logic        sec_tick;
  logic [31:0] status_word_sat;
  logic        sec_tick_sat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  soc_system_version_word_gen #(
    .FW_VERSION (FW),
    .BUILD_DATE (BUILD),
    .CLK_FREQ_HZ(CLK_HZ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .page_sel   (page_sel),
    .trig_in    (trig_in),
    .cnt_clear  (cnt_clear),
    .daq_busy   (daq_busy),
    .fifo_full  (fifo_full),
    .status_word(status_word),
    .sec_tick   (sec_tick)
  );

  // Second instance whose trigger count starts just below saturation.
  soc_system_version_word_gen #(
    .FW_VERSION   (FW),
    .BUILD_DATE   (BUILD),
    .CLK_FREQ_HZ  (CLK_HZ),
    .TRIG_CNT_INIT(32'hFFFF_FFFE)
  ) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .page_sel   (page_sel),
    .trig_in    (trig_in),
    .cnt_clear  (cnt_clear),
    .daq_busy   (daq_busy),
    .fifo_full  (fifo_full),
    .status_word(status_word_sat),
    .sec_tick   (sec_tick_sat)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int unsigned m_cycles;      // clock edges since reset or the last clear
  logic [31:0] m_trig;        // rising edges counted, saturating
  logic        m_trig_prev;   // trig_in seen at the previous edge
  logic [2:0]  m_last;        // most recent page_sel sample
  int          m_run;         // how many consecutive samples equal m_last
  logic [2:0]  m_page;        // accepted page
  logic [31:0] exp_status;
  logic        exp_tick;

  task automatic model_reset();
    m_cycles    = 0;
    m_trig      = 32'd0;
    m_trig_prev = 1'b0;
    m_last      = 3'd0;
    m_run       = 1;          // the reset value counts as one sample
    m_page      = 3'd0;
    exp_status  = FW;
    exp_tick    = 1'b0;
  endtask

  function automatic logic [31:0] page_word(input logic [2:0] p);
    case (p)
      3'd0:    return FW;
      3'd1:    return BUILD;
      3'd2:    return 32'(m_cycles / CLK_HZ);
      3'd3:    return m_trig;
      3'd4:    return {28'd0, m_trig_prev, fifo_full, daq_busy, 1'b1};
      default: return BEEF;
    endcase
  endfunction

  task automatic model_edge();
    exp_status = page_word(m_page);
    if (cnt_clear) begin
      m_cycles = 0;
      m_trig   = 32'd0;
      exp_tick = 1'b0;
    end else begin
      m_cycles++;
      if (trig_in && !m_trig_prev && m_trig != ALL_ONES) m_trig++;
      exp_tick = (m_cycles % CLK_HZ == 0);
    end
    m_trig_prev = trig_in;
    // A page is accepted once three consecutive samples agree.
    if (page_sel == m_last) m_run++;
    else m_run = 1;
    m_last = page_sel;
    if (m_run >= 3) m_page = m_last;
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Outputs are sampled 1 time unit after the edge, and
  // inputs are changed only at that point.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    #2;
    check("reset_word_async", status_word, FW);
    check("reset_tick_async", {31'd0, sec_tick}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    trig_in = 1'b1;
    repeat (hi) tick();
    trig_in = 1'b0;
    repeat (lo) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    page_sel  = 3'd0;
    trig_in   = 1'b0;
    cnt_clear = 1'b0;
    daq_busy  = 1'b0;
    fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Page 0 held, then page 1 with an exact 4-cycle latency.
    apply_reset();
    repeat (3) tick();
    check("page0_hold", status_word, FW);
    page_sel = 3'd1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("page1_early_t%0d", i), status_word, FW);
    end
    tick();
    check("page1_at_t4", status_word, BUILD);

    // Trigger counting and saturation on page 3.
    page_sel = 3'd3;
    trig_in  = 1'b0;
    apply_reset();
    repeat (3) tick();
    check("page3_not_yet", status_word, FW);
    tick();
    check("trig_start", status_word, 32'd0);
    check("sat_start", status_word_sat, 32'hFFFF_FFFE);
    repeat (3) pulse(3, 2);
    check("trig_3", status_word, 32'd3);
    check("sat_reach_max", status_word_sat, ALL_ONES);
    repeat (2) pulse(3, 2);
    check("trig_5", status_word, 32'd5);
    check("sat_stays_max", status_word_sat, ALL_ONES);
    pulse(20, 2);
    check("trig_held_high", status_word, 32'd6);
    trig_in   = 1'b1;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    tick();
    check("trig_clear_edge", status_word, 32'd0);
    repeat (2) tick();
    check("trig_edge_lost", status_word, 32'd0);
    trig_in = 1'b0;

    // Uptime on page 2 with a small prescaler.
    page_sel = 3'd2;
    apply_reset();
    for (int c = 1; c <= 34; c++) begin
      tick();
      check($sformatf("sec_tick_c%0d", c), {31'd0, sec_tick}, {31'd0, (c % 10 == 0)});
      check($sformatf("sec_tick_sat_c%0d", c), {31'd0, sec_tick_sat}, {31'd0, (c % 10 == 0)});
    end
    cnt_clear = 1'b1;
    tick();
    check("uptime_3", status_word, 32'd3);
    cnt_clear = 1'b0;
    tick();
    check("uptime_cleared", status_word, 32'd0);

    // Live status page and unused pages.
    daq_busy  = 1'b1;
    fifo_full = 1'b0;
    trig_in   = 1'b1;
    page_sel  = 3'd4;
    repeat (4) tick();
    check("status_page", status_word, 32'h0000_000B);
    for (int p = 5; p <= 7; p++) begin
      page_sel = 3'(p);
      repeat (4) tick();
      check($sformatf("page%0d_beef", p), status_word, BEEF);
    end
    trig_in  = 1'b0;
    daq_busy = 1'b0;

    // Glitching page_sel keeps the last accepted page, then reset mid-run.
    page_sel = 3'd1;
    repeat (4) tick();
    check("glitch_base", status_word, BUILD);
    for (int i = 0; i < 50; i++) begin
      page_sel = (i % 2 == 0) ? 3'd2 : 3'd3;
      tick();
      check($sformatf("glitch_hold_%0d", i), status_word, BUILD);
    end
    page_sel = 3'd2;
    #2;
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("post_reset_requal_%0d", i), status_word, FW);
    end
    tick();
    check("post_reset_uptime0", status_word, 32'd0);

    // Randomized phase against the model.
    page_sel = 3'd0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) page_sel = 3'($urandom_range(7));
      trig_in   = 1'($urandom_range(1));
      cnt_clear = ($urandom_range(47) == 0);
      daq_busy  = 1'($urandom_range(1));
      fifo_full = 1'($urandom_range(1));
      tick();
      check($sformatf("rand_word_%0d", i), status_word, exp_status);
      check($sformatf("rand_tick_%0d", i), {31'd0, sec_tick}, {31'd0, exp_tick});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
